// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and sizes for the packet round-robin arbiter
package arb_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DRAIN} arb_state_t;
   localparam int ARB_N_SRC    = 2;
   localparam int PKT_CNT_BITS = 8;
endpackage

// File: rtl/axis_pkt_rr_arbiter_beat_cap.sv
// rtl/axis_pkt_rr_arbiter_beat_cap.sv - per-packet beat counter, forced tlast and oversize pulse
// Instantiated by axis_pkt_rr_arbiter only when ARB_PKTCAP_EN is defined.
module axis_beat_cap
   import arb_pkg::*;
#(
   parameter int MAX_BEATS = 64
) (
   input  logic clk,
   input  logic resetn,
   input  logic clear,
   input  logic beat,
   input  logic in_tlast,
   output logic force_tlast,
   output logic err_oversize
);
   localparam logic [PKT_CNT_BITS-1:0] LAST_BEAT = PKT_CNT_BITS'(MAX_BEATS - 1);

   logic [PKT_CNT_BITS-1:0] beat_cnt;

   // Truncate only when the cap beat is not already the real end of packet.
   assign force_tlast = (beat_cnt == LAST_BEAT) && !in_tlast;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         beat_cnt     <= '0;
         err_oversize <= 1'b0;
      end else begin
         err_oversize <= beat && force_tlast;
         if (clear || (beat && (in_tlast || force_tlast))) begin
            beat_cnt <= '0;
         end else if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/axis_pkt_rr_arbiter.sv
// rtl/axis_pkt_rr_arbiter.sv - packet-granular round-robin arbiter for two AXI4SR producers
// Optional per-packet beat cap with drain is enabled by defining ARB_PKTCAP_EN.
module axis_pkt_rr_arbiter
   import arb_pkg::*;
#(
   parameter int AXI_DATA_BITS = 512,
   parameter int AXI_ID_BITS   = 6,
   parameter int BURST_PKTS    = 1,
   parameter int MAX_BEATS     = 64
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic                       en,
   input  logic [AXI_DATA_BITS-1:0]   s_axis_0_tdata,
   input  logic [AXI_DATA_BITS/8-1:0] s_axis_0_tkeep,
   input  logic [AXI_ID_BITS-1:0]     s_axis_0_tid,
   input  logic                       s_axis_0_tlast,
   input  logic                       s_axis_0_tvalid,
   output logic                       s_axis_0_tready,
   input  logic [AXI_DATA_BITS-1:0]   s_axis_1_tdata,
   input  logic [AXI_DATA_BITS/8-1:0] s_axis_1_tkeep,
   input  logic [AXI_ID_BITS-1:0]     s_axis_1_tid,
   input  logic                       s_axis_1_tlast,
   input  logic                       s_axis_1_tvalid,
   output logic                       s_axis_1_tready,
   output logic [AXI_DATA_BITS-1:0]   m_axis_tdata,
   output logic [AXI_DATA_BITS/8-1:0] m_axis_tkeep,
   output logic [AXI_ID_BITS-1:0]     m_axis_tid,
   output logic                       m_axis_tlast,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic                       busy,
   output logic                       grant,
   output logic                       err_oversize
);
   localparam logic [PKT_CNT_BITS-1:0] BURST_LAST = PKT_CNT_BITS'(BURST_PKTS - 1);

   if (BURST_PKTS < 1 || BURST_PKTS > 255) begin : g_bad_burst
      $error("BURST_PKTS must be in 1..255");
   end
   if (MAX_BEATS < 1 || MAX_BEATS > 256) begin : g_bad_max_beats
      $error("MAX_BEATS must be in 1..256");
   end

   arb_state_t              state, state_nxt;
   logic                    grant_nxt;
   logic [PKT_CNT_BITS-1:0] pkt_cnt, pkt_cnt_nxt;
   logic                    at_boundary, at_boundary_nxt;
   logic [ARB_N_SRC-1:0]    req;
   logic                    g_valid, g_last, o_valid, g_ready, fire, cap_hit;

   assign req     = {s_axis_1_tvalid, s_axis_0_tvalid};
   assign g_valid = grant ? s_axis_1_tvalid : s_axis_0_tvalid;
   assign g_last  = grant ? s_axis_1_tlast  : s_axis_0_tlast;
   assign o_valid = grant ? s_axis_0_tvalid : s_axis_1_tvalid;
   assign fire    = (state == ST_BUSY) && g_valid && m_axis_tready;

   assign m_axis_tdata = grant ? s_axis_1_tdata : s_axis_0_tdata;
   assign m_axis_tkeep = grant ? s_axis_1_tkeep : s_axis_0_tkeep;
   assign m_axis_tid   = grant ? s_axis_1_tid   : s_axis_0_tid;
   assign m_axis_tlast = g_last | cap_hit;

   assign s_axis_0_tready = g_ready && !grant;
   assign s_axis_1_tready = g_ready && grant;
   assign busy            = (state != ST_IDLE);

`ifdef ARB_PKTCAP_EN
   axis_beat_cap #(.MAX_BEATS(MAX_BEATS)) u_beat_cap (
      .clk          (aclk),
      .resetn       (aresetn),
      .clear        (state == ST_IDLE),
      .beat         (fire),
      .in_tlast     (g_last),
      .force_tlast  (cap_hit),
      .err_oversize (err_oversize)
   );
`else
   assign cap_hit      = 1'b0;
   assign err_oversize = 1'b0;
`endif

   always_comb begin
      state_nxt       = state;
      grant_nxt       = grant;
      pkt_cnt_nxt     = pkt_cnt;
      at_boundary_nxt = at_boundary;
      m_axis_tvalid   = 1'b0;
      g_ready         = 1'b0;
      case (state)
         ST_IDLE: begin
            if (en && |req) begin
               // On a tie the requester that did not hold the last grant wins.
               grant_nxt       = (&req) ? ~grant : req[1];
               pkt_cnt_nxt     = '0;
               at_boundary_nxt = 1'b0;
               state_nxt       = ST_BUSY;
            end
         end
         ST_BUSY: begin
            m_axis_tvalid = g_valid;
            g_ready       = m_axis_tready;
            if (fire && cap_hit) begin
               at_boundary_nxt = 1'b0;
               state_nxt       = ST_DRAIN;
            end else if (fire && g_last) begin
               if (pkt_cnt == BURST_LAST || !en) begin
                  state_nxt = ST_IDLE;
               end else begin
                  pkt_cnt_nxt     = pkt_cnt + 1'b1;
                  at_boundary_nxt = 1'b1;
               end
            end else if (fire) begin
               at_boundary_nxt = 1'b0;
            end else if (at_boundary && !g_valid && o_valid) begin
               // An idle grantee between packets must not starve the other side.
               state_nxt = ST_IDLE;
            end
         end
`ifdef ARB_PKTCAP_EN
         ST_DRAIN: begin
            g_ready = 1'b1;
            if (g_valid && g_last) begin
               state_nxt = ST_IDLE;
            end
         end
`endif
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state       <= ST_IDLE;
         grant       <= 1'b1;
         pkt_cnt     <= '0;
         at_boundary <= 1'b0;
      end else begin
         state       <= state_nxt;
         grant       <= grant_nxt;
         pkt_cnt     <= pkt_cnt_nxt;
         at_boundary <= at_boundary_nxt;
      end
   end
endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// tb/tb_axis_pkt_rr_arbiter.sv - scoreboard bench for axis_pkt_rr_arbiter (BURST_PKTS 1 and 3)
module tb_axis_pkt_rr_arbiter;
`ifdef ARB_PKTCAP_EN
   localparam int CAP  = 1;
   localparam int MAXB = 4;
`else
   localparam int CAP  = 0;
   localparam int MAXB = 64;
`endif

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;
   int cyc;
   always @(posedge clk) cyc <= cyc + 1;

   logic        en      [2];
   logic [31:0] s_data  [2][2];
   logic [3:0]  s_keep  [2][2];
   logic [3:0]  s_id    [2][2];
   logic        s_last  [2][2];
   logic        s_valid [2][2];
   logic        s_ready [2][2];
   logic [31:0] m_data  [2];
   logic [3:0]  m_keep  [2];
   logic [3:0]  m_id    [2];
   logic        m_last  [2];
   logic        m_valid [2];
   logic        m_ready [2];
   logic        busy    [2];
   logic        grant   [2];
   logic        err     [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      axis_pkt_rr_arbiter #(
         .AXI_DATA_BITS(32), .AXI_ID_BITS(4),
         .BURST_PKTS(g == 0 ? 1 : 3), .MAX_BEATS(MAXB)
      ) dut (
         .aclk(clk), .aresetn(rstn), .en(en[g]),
         .s_axis_0_tdata(s_data[g][0]), .s_axis_0_tkeep(s_keep[g][0]), .s_axis_0_tid(s_id[g][0]),
         .s_axis_0_tlast(s_last[g][0]), .s_axis_0_tvalid(s_valid[g][0]), .s_axis_0_tready(s_ready[g][0]),
         .s_axis_1_tdata(s_data[g][1]), .s_axis_1_tkeep(s_keep[g][1]), .s_axis_1_tid(s_id[g][1]),
         .s_axis_1_tlast(s_last[g][1]), .s_axis_1_tvalid(s_valid[g][1]), .s_axis_1_tready(s_ready[g][1]),
         .m_axis_tdata(m_data[g]), .m_axis_tkeep(m_keep[g]), .m_axis_tid(m_id[g]),
         .m_axis_tlast(m_last[g]), .m_axis_tvalid(m_valid[g]), .m_axis_tready(m_ready[g]),
         .busy(busy[g]), .grant(grant[g]), .err_oversize(err[g])
      );
   end

   int checks = 0;
   int failures = 0;
   logic [36:0] exp_q [4][$];
   int seq [4];
   int src_log [2][$];
   int beat_cyc [2][$];
   int obs [2];
   int err_seen [2];
   int err_exp [2];
   bit bp_mode = 1'b0;

   task automatic chk(input bit ok, input string name, input longint act, input longint exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Reference: each packet of len beats from source s appears on the output in order,
   // cut to MAXB beats (last one flagged) when the cap is built in.
   task automatic send_pkt(input int d, input int s, input int len, input int max_gap);
      int idx, n, t;
      logic [31:0] dat [$];
      logic [3:0]  kp [$];
      idx = d * 2 + s;
      n = (CAP != 0 && len > MAXB) ? MAXB : len;
      if (n != len) err_exp[d]++;
      for (int i = 0; i < len; i++) begin
         dat.push_back({s[0], d[0], 30'(seq[idx])});
         seq[idx]++;
         kp.push_back(4'($urandom_range(1, 15)));
         if (i < n) exp_q[idx].push_back({(i == n - 1), kp[i], dat[i]});
      end
      for (int i = 0; i < len; i++) begin
         repeat ($urandom_range(0, max_gap)) begin
            @(negedge clk);
            s_valid[d][s] = 1'b0;
         end
         @(negedge clk);
         s_data[d][s]  = dat[i];
         s_keep[d][s]  = kp[i];
         s_id[d][s]    = 4'(s);
         s_last[d][s]  = (i == len - 1);
         s_valid[d][s] = 1'b1;
         t = 0;
         forever begin
            #4;
            if (s_ready[d][s]) break;
            @(negedge clk);
            t++;
            if (t > 3000) begin
               chk(1'b0, "send_timeout", idx, 0);
               s_valid[d][s] = 1'b0;
               return;
            end
         end
      end
      @(posedge clk);
      #1 s_valid[d][s] = 1'b0;
   endtask

   task automatic send_n(input int d, input int s, input int npk, input int len, input int max_gap);
      for (int k = 0; k < npk; k++)
         send_pkt(d, s, (len == 0) ? int'($urandom_range(1, 6)) : len, max_gap);
   endtask

   task automatic monitor(input int d);
      bit in_pkt = 1'b0;
      int cur = 0;
      int s;
      logic [36:0] got, want;
      forever begin
         @(negedge clk);
         #4;
         if (!rstn) begin
            in_pkt = 1'b0;
         end else begin
            if (err[d]) err_seen[d]++;
            if (!busy[d])
               chk(!(m_valid[d] || s_ready[d][0] || s_ready[d][1]), "idle_quiet",
                   {m_valid[d], s_ready[d][1], s_ready[d][0]}, 0);
            if (m_valid[d] && m_ready[d]) begin
               s = int'(m_id[d]);
               chk(s < 2, "tid_range", s, 1);
               chk(grant[d] == s[0], "grant_match", grant[d], s);
               if (in_pkt) chk(s == cur, "no_interleave", s, cur);
               got = {m_last[d], m_keep[d], m_data[d]};
               if (s < 2 && exp_q[d * 2 + s].size() > 0) begin
                  want = exp_q[d * 2 + s].pop_front();
                  chk(got == want, "beat", got, want);
               end else begin
                  chk(1'b0, "unexpected_beat", got, 0);
               end
               obs[d]++;
               beat_cyc[d].push_back(cyc);
               if (m_last[d]) begin
                  in_pkt = 1'b0;
                  src_log[d].push_back(s);
               end else begin
                  in_pkt = 1'b1;
                  cur = s;
               end
            end
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      #4;
      for (int d = 0; d < 2; d++) begin
         chk(busy[d] == 1'b0, "rst_busy", busy[d], 0);
         chk(grant[d] == 1'b1, "rst_grant", grant[d], 1);
         chk(s_ready[d][0] == 1'b0, "rst_ready0", s_ready[d][0], 0);
         chk(s_ready[d][1] == 1'b0, "rst_ready1", s_ready[d][1], 0);
         chk(m_valid[d] == 1'b0, "rst_mvalid", m_valid[d], 0);
         chk(err[d] == 1'b0, "rst_err", err[d], 0);
      end
      @(negedge clk);
      rstn = 1'b1;
      for (int d = 0; d < 2; d++) begin
         src_log[d].delete();
         beat_cyc[d].delete();
      end
   endtask

   task automatic settle();
      int t = 0;
      while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      for (int i = 0; i < 4; i++) chk(exp_q[i].size() == 0, "drain_empty", exp_q[i].size(), 0);
      repeat (4) @(negedge clk);
   endtask

   task automatic chk_srcs(input int d, input int e [$]);
      chk(src_log[d].size() == e.size(), "src_count", src_log[d].size(), e.size());
      for (int i = 0; i < e.size() && i < src_log[d].size(); i++)
         chk(src_log[d][i] == e[i], "src_order", src_log[d][i], e[i]);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         en[d] = 1'b1;
         for (int s = 0; s < 2; s++) begin
            s_valid[d][s] = 1'b0; s_last[d][s] = 1'b0;
            s_data[d][s] = '0; s_keep[d][s] = '0; s_id[d][s] = '0;
         end
      end
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) m_ready[d] = bp_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog cycles=%0d limit=%0d", cyc, 100000);
      $fatal(1);
   end

   initial begin
      int base, n5, t, e0;
      fork
         monitor(0);
         monitor(1);
      join_none

      // Single source, 3 packets of 4 beats: one idle output cycle between packets.
      do_reset();
      send_n(0, 0, 3, 4, 0);
      settle();
      chk_srcs(0, '{0, 0, 0});
      chk(beat_cyc[0].size() == 12, "t1_beats", beat_cyc[0].size(), 12);
      for (int k = 1; k < beat_cyc[0].size(); k++)
         chk(beat_cyc[0][k] - beat_cyc[0][k - 1] == ((k % 4 == 0) ? 2 : 1), "t1_spacing",
             beat_cyc[0][k] - beat_cyc[0][k - 1], (k % 4 == 0) ? 2 : 1);

      // BURST_PKTS=1, both continuously valid: strict alternation.
      do_reset();
      fork
         send_n(0, 0, 2, 2, 0);
         send_n(0, 1, 2, 2, 0);
      join
      settle();
      chk_srcs(0, '{0, 1, 0, 1});

      // BURST_PKTS=3, both continuously valid.
      do_reset();
      fork
         send_n(1, 0, 3, 2, 0);
         send_n(1, 1, 3, 2, 0);
      join
      settle();
      chk_srcs(1, '{0, 0, 0, 1, 1, 1});

      // Grantee goes idle at a boundary while the other waits: released after one cycle.
      do_reset();
      fork
         send_n(1, 0, 1, 2, 0);
         send_n(1, 1, 1, 2, 0);
      join
      settle();
      chk_srcs(1, '{0, 1});
      if (beat_cyc[1].size() == 4)
         chk(beat_cyc[1][2] - beat_cyc[1][1] == 3, "release_gap", beat_cyc[1][2] - beat_cyc[1][1], 3);
      else
         chk(1'b0, "release_beats", beat_cyc[1].size(), 4);

      // en dropped during beat 2 of a 5-beat packet.
      do_reset();
      base = obs[1];
      n5 = (CAP != 0 && MAXB < 5) ? MAXB : 5;
      fork
         begin
            send_pkt(1, 0, 5, 0);
            send_pkt(1, 0, 3, 0);
         end
         begin
            t = 0;
            while (obs[1] < base + 1 && t < 500) begin @(negedge clk); t++; end
            en[1] = 1'b0;
            t = 0;
            while (obs[1] < base + n5 && t < 500) begin @(negedge clk); t++; end
            repeat (20) @(negedge clk);
            #4;
            chk(busy[1] == 1'b0, "en_low_busy", busy[1], 0);
            chk(obs[1] == base + n5, "en_low_beats", obs[1] - base, n5);
            chk(s_ready[1][0] == 1'b0, "en_low_ready", s_ready[1][0], 0);
            @(negedge clk);
            en[1] = 1'b1;
         end
      join
      settle();
      chk(obs[1] == base + n5 + 3, "en_resume_beats", obs[1] - base, n5 + 3);

`ifdef ARB_PKTCAP_EN
      // Oversize packet truncated to MAXB beats, rest drained, next packet intact.
      do_reset();
      e0 = err_seen[0];
      send_pkt(0, 0, 7, 0);
      send_pkt(0, 0, 2, 0);
      settle();
      chk_srcs(0, '{0, 0});
      chk(beat_cyc[0].size() == MAXB + 2, "cap_beats", beat_cyc[0].size(), MAXB + 2);
      chk(err_seen[0] - e0 == 1, "cap_err_pulse", err_seen[0] - e0, 1);
`else
      e0 = 0;
`endif

      // Random lengths, gaps and output backpressure on both instances.
      do_reset();
      bp_mode = 1'b1;
      fork
         send_n(0, 0, 250, 0, 2);
         send_n(0, 1, 250, 0, 2);
         send_n(1, 0, 250, 0, 2);
         send_n(1, 1, 250, 0, 2);
      join
      settle();
      bp_mode = 1'b0;

      for (int d = 0; d < 2; d++)
         chk(err_seen[d] == err_exp[d], "err_count", err_seen[d], err_exp[d]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/axis_pkt_rr_arbiter.md
# axis_pkt_rr_arbiter

Packet-granular round-robin arbiter that shares the single RDMA QSFP0 transmit stream (`axis_rdma_0_src`) between two AXI4SR producers in user logic, e.g. the host-to-network processing path and a second generator. It grants whole packets (tlast-delimited), never interleaves beats of different packets, and adds no latency to beats once a grant is held. It sits between the producers and `axis_rdma_0_src` in `design_user_logic_c0_*`.

## Interface
- `BURST_PKTS`, 1: packets a grantee may send back-to-back before the grant is re-arbitrated (1..255).
- `MAX_BEATS`, 64: beat cap per packet; used only with `ARB_PKTCAP_EN`.
- `aclk`  in  1  clock.
- `aresetn`  in  1  synchronous active-low reset.
- `en`  in  1  arbitration enable; low blocks new grants, and the current packet completes.
- `s_axis_0`  AXI4SR.s  AXI_DATA_BITS  requester 0 (tdata/tkeep/tid/tlast/tvalid/tready).
- `s_axis_1`  AXI4SR.s  AXI_DATA_BITS  requester 1.
- `m_axis`  AXI4SR.m  AXI_DATA_BITS  shared output, toward `axis_rdma_0_src`.
- `busy`  out  1  high while a grant is held.
- `grant`  out  1  index of the current or last grantee.
- `err_oversize`  out  1  one-cycle pulse on packet truncation; tied 0 without `ARB_PKTCAP_EN`.

## Operation
- States: IDLE, BUSY, DRAIN (DRAIN exists only with `ARB_PKTCAP_EN`).
- **IDLE:** all `s_axis_*.tready`=0, `m_axis.tvalid`=0.
  - If `en` is high and any tvalid is high, register the grant. The requester ≠ `grant` wins when both are valid; the sole valid requester wins otherwise.
  - Load `pkt_cnt`=0 and enter BUSY.
- **BUSY:** combinational mux of the grantee.
  - `m_axis.{tdata,tkeep,tid,tlast,tvalid}` = `s_axis_g`.
  - `s_axis_g.tready` = `m_axis.tready`.
  - The other requester's tready = 0.
- **Handshake with tlast (BUSY):**
  - If `pkt_cnt`=`BURST_PKTS`-1 or `en` is low: go to IDLE.
  - Else: increment `pkt_cnt` and set `at_boundary`=1.
- **At a packet boundary (`at_boundary`=1, no beat yet accepted of the next packet):** if the grantee's tvalid is low and the other requester's tvalid is high, release to IDLE, so an idle grantee cannot starve the other requester. The first accepted beat clears `at_boundary`.
- **Never** switch grant mid-packet.
- `m_axis` beats are AXI-compliant: tvalid is not withdrawn before tready because it is the grantee's own tvalid; upstream must comply.

## Timing
- Reset (`aresetn`=0 at a clock edge) forces:
  - state=IDLE, `grant`=1 (so requester 0 wins the first tie), `busy`=0, `pkt_cnt`=0, `at_boundary`=0, `err_oversize`=0;
  - all tready=0 and `m_axis.tvalid`=0 in the following cycle.
- Reset mid-packet truncates the packet; producers must also be reset.
- Grant latency: tvalid seen in IDLE at cycle N, first beat can transfer at N+1.
- Beat latency in BUSY: 0 cycles (combinational). Throughput is 1 beat/cycle.
- Re-arbitration costs exactly one idle cycle on the output between grants.
- `en` falling mid-packet: the packet completes, then IDLE. `en` low in IDLE: no grant.
- Simultaneous tlast and release condition: tlast handling takes precedence, and the result is the same IDLE.

## Configuration
- `ARB_PKTCAP_EN` defined: an 8-bit `beat_cnt` counts accepted beats of the current packet.
  - If beat number `MAX_BEATS` is accepted without tlast, force `m_axis.tlast`=1 on that beat, pulse `err_oversize`, and enter DRAIN.
  - DRAIN: `s_axis_g.tready`=1, `m_axis.tvalid`=0; discard beats until the input tlast is accepted, then go to IDLE.
- Not defined: no counter and no DRAIN; packets of any length pass unmodified; `err_oversize`=0.

## Structure
- Package `arb_pkg`:
  - `typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DRAIN} arb_state_t`
  - `localparam ARB_N_SRC = 2`
  - `localparam PKT_CNT_BITS = 8`
- One sub-module, `axis_beat_cap`: the beat counter, forced tlast, and DRAIN control, instantiated only under `ARB_PKTCAP_EN`. The arbiter FSM and mux stay in the top module.

## Test plan
- Only `s_axis_0` sends 3 packets of 4 beats, `m_axis.tready`=1:
  - the output carries 12 beats with tlast on beats 4, 8, 12;
  - `grant`=0 throughout;
  - one idle cycle between packets.
- Both requesters are continuously valid, 2-beat packets, `BURST_PKTS`=1: output packet sources alternate 0,1,0,1 with no beat interleaving.
- `BURST_PKTS`=3, both valid: sources are 0,0,0,1,1,1. Then requester 0 goes idle at a boundary while requester 1 is valid: release happens within 1 cycle.
- Random `m_axis.tready` backpressure, 1000 random packets: per-source data order is preserved and no beat is lost or duplicated.
- `en` dropped on beat 2 of a 5-beat packet: all 5 beats complete, then no further grant until `en`=1.
- With `ARB_PKTCAP_EN`, `MAX_BEATS`=4, a 7-beat packet is sent:
  - output is 4 beats, tlast forced on beat 4;
  - `err_oversize` pulses once;
  - 3 beats are drained;
  - the next packet passes intact.
